// File: rtl/funnel_ctrl_n.sv
// Funnel controller: splits each target beat into DEPTH/lanes initiator phases with a bit-reversed phase select.
// Optional FUNNEL_CTRL_STALL_CNT_EN adds a saturating stall_cnt output.
module funnel_ctrl_n #(
    parameter int                N_INIT   = 4,
    parameter int                DEPTH    = 8,
    parameter int                MODE_W   = 8,
    parameter logic [MODE_W-1:0] MODE_RST = MODE_W'(2),
    localparam int               SEL_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              t_0_req,
    output logic              t_0_ack,
    input  logic              t_cfg_req,
    input  logic [MODE_W-1:0] t_cfg_data,
    output logic              t_cfg_ack,
    output logic [N_INIT-1:0] i_req,
    input  logic [N_INIT-1:0] i_ack,
    output logic [SEL_W-1:0]  sel,
    output logic [MODE_W-1:0] mode_q,
    output logic              busy
`ifdef FUNNEL_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // state_q | meaning
    // 0       | frame boundary; config may be accepted while t_0_req is low
    // nonzero | mid-frame; index of the next phase to issue
    logic [SEL_W-1:0]  state_q, state_d, state_nxt;
    logic [MODE_W-1:0] mode_d;
    logic              busy_q, busy_d;
    logic [2:0]        k;
    logic [31:0]       lanes;
    logic              valid;
    logic [N_INIT-1:0] lane_mask;
    logic              all_ack, progress, last, cfg_accept;

    always_comb begin
        k         = mode_q[2:0];
        lanes     = 32'd1 << k;
        valid     = (lanes <= 32'(N_INIT));
        lane_mask = '0;
        for (int j = 0; j < N_INIT; j++) begin
            lane_mask[j] = (32'(j) < lanes);
        end
        all_ack    = &(i_ack | ~lane_mask);
        progress   = t_0_req & valid & all_ack;
        // Truncation to SEL_W bits is the mod-DEPTH wrap; lanes == DEPTH adds zero.
        state_nxt  = state_q + SEL_W'(lanes);
        last       = (state_nxt == '0);
        t_0_ack    = progress & last;
        i_req      = (t_0_req & valid) ? lane_mask : '0;
        t_cfg_ack  = (state_q == '0) & ~t_0_req;
        cfg_accept = t_cfg_req & t_cfg_ack;
        state_d    = progress ? state_nxt : state_q;
        mode_d     = cfg_accept ? t_cfg_data : mode_q;
        busy_d     = (state_d != '0);
    end

    always_comb begin
        sel = '0;
        for (int b = 0; b < SEL_W; b++) begin
            sel[b] = state_q[SEL_W-1-b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            mode_q  <= MODE_RST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

`ifdef FUNNEL_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cfg_accept) begin
            stall_cnt_d = '0;
        end else if (t_0_req && valid && !all_ack && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_funnel_ctrl_n.sv
// Self-checking bench for funnel_ctrl_n (N_INIT=4, DEPTH=8): per-cycle model compare plus directed literals.
module tb_funnel_ctrl_n;

    logic       clk = 1'b0;
    logic       reset, t_0_req, t_cfg_req;
    logic [7:0] t_cfg_data;
    logic [3:0] i_ack;
    logic       t_0_ack, t_cfg_ack, busy;
    logic [3:0] i_req;
    logic [2:0] sel;
    logic [7:0] mode_q;
`ifdef FUNNEL_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    funnel_ctrl_n #(.N_INIT(4), .DEPTH(8), .MODE_W(8), .MODE_RST(8'd2)) dut (
        .clk        (clk),
        .reset      (reset),
        .t_0_req    (t_0_req),
        .t_0_ack    (t_0_ack),
        .t_cfg_req  (t_cfg_req),
        .t_cfg_data (t_cfg_data),
        .t_cfg_ack  (t_cfg_ack),
        .i_req      (i_req),
        .i_ack      (i_ack),
        .sel        (sel),
        .mode_q     (mode_q),
        .busy       (busy)
`ifdef FUNNEL_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame (count of phases already issued), mode word, stall count.
    int m_pos;
    int m_mode;
    int m_stall;
    int m_lanes, m_mask;
    bit m_valid, m_all, m_prog, m_cfg_ok;

    function automatic int bitrev3(input int p);
        int r = 0;
        for (int b = 0; b < 3; b++) begin
            if ((p >> b) % 2 == 1) r += (1 << (2 - b));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        m_lanes  = 1 << (m_mode % 8);
        m_valid  = (m_lanes <= 4);
        m_mask   = m_valid ? (1 << m_lanes) - 1 : 0;
        m_all    = ((int'(i_ack) & m_mask) == m_mask);
        m_prog   = t_0_req && m_valid && m_all;
        m_cfg_ok = (m_pos == 0) && !t_0_req;
        if (chk_en) begin
            check("m_i_req",   i_req,     (t_0_req && m_valid) ? m_mask : 0);
            check("m_t_0_ack", t_0_ack,   (m_prog && ((m_pos + m_lanes) % 8 == 0)) ? 1 : 0);
            check("m_cfg_ack", t_cfg_ack, m_cfg_ok ? 1 : 0);
            check("m_sel",     sel,       bitrev3(m_pos));
            check("m_mode",    mode_q,    m_mode);
            check("m_busy",    busy,      (m_pos != 0) ? 1 : 0);
`ifdef FUNNEL_CTRL_STALL_CNT_EN
            check("m_stall",   stall_cnt, m_stall);
`endif
        end
        if (reset) begin
            m_pos   = 0;
            m_mode  = 2;
            m_stall = 0;
        end else begin
            if (m_prog) m_pos = (m_pos + m_lanes) % 8;
            if (t_cfg_req && m_cfg_ok) begin
                m_mode  = t_cfg_data;
                m_stall = 0;
            end else if (t_0_req && m_valid && !m_all && m_stall < 65535) begin
                m_stall++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] data);
        t_cfg_req  = 1'b1;
        t_cfg_data = data;
        #1;
        check("cfg_ack_idle", t_cfg_ack, 1);
        cyc();
        t_cfg_req = 1'b0;
        #1;
        check("cfg_mode", mode_q, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    logic [2:0] exp2 [8];

    initial begin
        exp2 = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
        reset = 1'b1; t_0_req = 1'b0; t_cfg_req = 1'b0; t_cfg_data = 8'd0; i_ack = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        check("rst_mode", mode_q, 8'd2);
        check("rst_sel", sel, 3'b000);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // 4 lanes, acks high: two phases
        t_0_req = 1'b1; i_ack = 4'hF;
        #1;
        check("t1_ireq", i_req, 4'b1111);
        check("t1_sel0", sel, 3'b000);
        check("t1_ack0", t_0_ack, 0);
        cyc();
        #1;
        check("t1_sel1", sel, 3'b001);
        check("t1_ack1", t_0_ack, 1);
        cyc();
        t_0_req = 1'b0;
        #1;
        check("t1_idle_busy", busy, 0);

        // 1 lane: eight phases with bit-reversed select
        do_cfg(8'd0);
        t_0_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_ireq", i_req, 4'b0001);
            check("t2_sel", sel, exp2[i]);
            check("t2_ack", t_0_ack, (i == 7) ? 1 : 0);
            cyc();
        end
        t_0_req = 1'b0;

        // 2 lanes, stall lane 1 for three cycles at state 2
        do_cfg(8'd1);
        t_0_req = 1'b1; i_ack = 4'hF;
        cyc();
        i_ack = 4'b1101;
        repeat (3) begin
            #1;
            check("t3_sel_hold", sel, 3'b010);
            check("t3_ack_stall", t_0_ack, 0);
            check("t3_ireq", i_req, 4'b0011);
            cyc();
        end
`ifdef FUNNEL_CTRL_STALL_CNT_EN
        check("t3_stall_cnt", stall_cnt, 16'd3);
`endif
        i_ack = 4'hF;
        #1;
        check("t3_sel2", sel, 3'b010);
        cyc();
        #1;
        check("t3_sel4", sel, 3'b001);
        cyc();
        #1;
        check("t3_sel6", sel, 3'b011);
        check("t3_ack6", t_0_ack, 1);
        cyc();
        t_0_req = 1'b0;

        // cfg write mid-frame waits for the frame end and t_0_req low
        do_cfg(8'd2);
        t_0_req = 1'b1;
        cyc();
        i_ack = 4'h0; t_cfg_req = 1'b1; t_cfg_data = 8'd1;
        #1;
        check("t4_cfg_mid", t_cfg_ack, 0);
        check("t4_busy", busy, 1);
        cyc();
        t_0_req = 1'b0;
        #1;
        check("t4_cfg_mid_idle", t_cfg_ack, 0);
        cyc();
        t_0_req = 1'b1; i_ack = 4'hF;
        #1;
        check("t4_ack", t_0_ack, 1);
        check("t4_cfg_req_hi", t_cfg_ack, 0);
        cyc();
        t_0_req = 1'b0;
        #1;
        check("t4_cfg_ok", t_cfg_ack, 1);
        check("t4_mode_old", mode_q, 8'd2);
        cyc();
        t_cfg_req = 1'b0;
        #1;
        check("t4_mode_new", mode_q, 8'd1);
        t_0_req = 1'b1;
        #1;
        check("t4_ireq", i_req, 4'b0011);
        t_0_req = 1'b0;
        cyc();

        // invalid mode: 8 lanes on a 4-lane funnel
        do_cfg(8'd3);
        t_0_req = 1'b1; i_ack = 4'hF;
        repeat (3) begin
            #1;
            check("t5_ireq", i_req, 4'b0000);
            check("t5_ack", t_0_ack, 0);
            check("t5_sel", sel, 3'b000);
            cyc();
        end
        t_0_req = 1'b0;
        do_cfg(8'd2);
        t_0_req = 1'b1;
        #1;
        check("t5_resume_ireq", i_req, 4'b1111);
        cyc();
        #1;
        check("t5_resume_sel", sel, 3'b001);
        cyc();
        t_0_req = 1'b0;

        // reset mid-frame at state 6
        do_cfg(8'd1);
        t_0_req = 1'b1; i_ack = 4'hF;
        repeat (3) cyc();
        #1;
        check("t6_sel6", sel, 3'b011);
        check("t6_busy6", busy, 1);
        i_ack = 4'h0; reset = 1'b1;
        #1;
        check("t6_no_ack", t_0_ack, 0);
        cyc();
        reset = 1'b0; t_0_req = 1'b0;
        #1;
        check("t6_sel", sel, 3'b000);
        check("t6_busy", busy, 0);
        check("t6_mode", mode_q, 8'd2);
        t_0_req = 1'b1; i_ack = 4'hF;
        #1;
        check("t6_new_ack0", t_0_ack, 0);
        cyc();
        #1;
        check("t6_new_sel1", sel, 3'b001);
        check("t6_new_ack1", t_0_ack, 1);
        cyc();
        t_0_req = 1'b0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
